stoch_stream_gen: RTL and testbench

//  Upstream stage of the reservoir node. Turns three 16-bit binary operands into

---
 rtl/sng_pkg.sv | 21 ++
 rtl/lfsr_16bit.sv | 30 +++
 rtl/stoch_stream_gen.sv | 136 +++++++++++++
 tb/tb_stoch_stream_gen.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sng_pkg.sv
// sng_pkg: shared constants, FSM state type and rotate helper for the
// stochastic stream generator (stoch_stream_gen and lfsr_16bit).
package sng_pkg;

    localparam int unsigned       LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sng_state_e;

    // Left-rotate built from a doubled word so any amount below LFSR_W is legal.
    function automatic logic [LFSR_W-1:0] rotl(input logic [LFSR_W-1:0] x,
                                               input int unsigned       amt);
        logic [2*LFSR_W-1:0] dbl;
        dbl = {x, x} << (amt % LFSR_W);
        return dbl[2*LFSR_W-1:LFSR_W];
    endfunction

endpackage

// File: rtl/lfsr_16bit.sv
// lfsr_16bit: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left.
// 'load' takes priority over 'en'; a non-zero seed keeps it out of the lock-up state.
module lfsr_16bit
    import sng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_VAL = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/stoch_stream_gen.sv
// stoch_stream_gen: turns three 16-bit operands into stochastic bitstreams, one frame
// of FRAME_LEN bits per accepted operand set. SNG_RESEED_EN reseeds the LFSR per transfer.
module stoch_stream_gen
    import sng_pkg::*;
#(
    parameter int unsigned       FRAME_LEN = 256,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int unsigned       ROT_I     = 5,
    parameter int unsigned       ROT_W2    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LFSR_W-1:0] w1_val,
    input  logic [LFSR_W-1:0] i1_val,
    input  logic [LFSR_W-1:0] w2_val,
    output logic              w1_bs,
    output logic              i1_bs,
    output logic              w2_bs,
    output logic [LFSR_W-1:0] rand_word,
    output logic              bs_valid,
    output logic              Nc
);

    localparam int unsigned      CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    sng_state_e        state_q;
    sng_state_e        state_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [LFSR_W-1:0] w1_q;
    logic [LFSR_W-1:0] i1_q;
    logic [LFSR_W-1:0] w2_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] rot_i;
    logic [LFSR_W-1:0] rot_w2;
    logic              last_bit;
    logic              xfer;
    logic              lfsr_en;
    logic              lfsr_load;

    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A transfer on the last bit keeps RUN so frames follow without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer) state_d = RUN;
            RUN:     if (last_bit && !xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        bs_valid = 1'b0;
        Nc       = 1'b0;
        w1_bs    = 1'b0;
        i1_bs    = 1'b0;
        w2_bs    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                in_ready = last_bit;
                bs_valid = 1'b1;
                Nc       = last_bit;
                w1_bs    = (w1_q > lfsr_q);
                i1_bs    = (i1_q > rot_i);
                w2_bs    = (w2_q > rot_w2);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Counter only wraps through the last-bit rule and sits at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else if (state_q == RUN && !last_bit) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end else begin
            bit_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1_q <= '0;
            i1_q <= '0;
            w2_q <= '0;
        end else if (xfer) begin
            w1_q <= w1_val;
            i1_q <= i1_val;
            w2_q <= w2_val;
        end
    end

    assign lfsr_en = (state_q == RUN);

`ifdef SNG_RESEED_EN
    assign lfsr_load = xfer;
`else
    assign lfsr_load = 1'b0;
`endif

    lfsr_16bit #(
        .RESET_VAL (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .load  (lfsr_load),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // The rotated views decorrelate the three streams drawn from one LFSR word.
    assign rot_i     = rotl(lfsr_q, ROT_I);
    assign rot_w2    = rotl(lfsr_q, ROT_W2);
    assign rand_word = lfsr_q;

endmodule

// File: tb/tb_stoch_stream_gen.sv
// tb_stoch_stream_gen: scoreboard bench for stoch_stream_gen (FRAME_LEN=256) plus a
// second instance with FRAME_LEN=65535 used for exact full-period ones counts.
module tb_stoch_stream_gen;

    localparam int          FL      = 256;
    localparam int          FL_LONG = 65535;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] w1_val, i1_val, w2_val;
    logic        w1_bs, i1_bs, w2_bs;
    logic [15:0] rand_word;
    logic        bs_valid;
    logic        Nc;

    logic        rst_n_long;
    logic        in_valid_long;
    logic        in_ready_long;
    logic [15:0] w1_val_long, i1_val_long, w2_val_long;
    logic        w1_bs_long, i1_bs_long, w2_bs_long;
    logic [15:0] rand_word_long;
    logic        bs_valid_long;
    logic        Nc_long;

    always #5 clk = ~clk;

    stoch_stream_gen #(.FRAME_LEN(FL), .SEED(SEED), .ROT_I(5), .ROT_W2(11)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .w1_val(w1_val), .i1_val(i1_val), .w2_val(w2_val),
        .w1_bs(w1_bs), .i1_bs(i1_bs), .w2_bs(w2_bs),
        .rand_word(rand_word), .bs_valid(bs_valid), .Nc(Nc)
    );

    stoch_stream_gen #(.FRAME_LEN(FL_LONG), .SEED(SEED), .ROT_I(5), .ROT_W2(11)) dut_long (
        .clk(clk), .rst_n(rst_n_long), .in_valid(in_valid_long), .in_ready(in_ready_long),
        .w1_val(w1_val_long), .i1_val(i1_val_long), .w2_val(w2_val_long),
        .w1_bs(w1_bs_long), .i1_bs(i1_bs_long), .w2_bs(w2_bs_long),
        .rand_word(rand_word_long), .bs_valid(bs_valid_long), .Nc(Nc_long)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    endtask

    // Reference model: independent behavioural description of one clock edge.
    bit          m_run;
    int          m_cnt;
    logic [15:0] m_lfsr;
    logic [15:0] m_w1, m_i1, m_w2;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic logic [15:0] rot16(input logic [15:0] x, input int r);
        return (x << r) | (x >> (16 - r));
    endfunction

    function automatic logic [21:0] model_outputs();
        logic rdy, nc, b1, b2, b3;
        rdy = !m_run || (m_cnt == FL - 1);
        nc  = m_run && (m_cnt == FL - 1);
        b1  = m_run && (m_w1 > m_lfsr);
        b2  = m_run && (m_i1 > rot16(m_lfsr, 5));
        b3  = m_run && (m_w2 > rot16(m_lfsr, 11));
        return {rdy, m_run, nc, b1, b2, b3, m_lfsr};
    endfunction

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = 0;
        m_lfsr = SEED;
        m_w1   = '0;
        m_i1   = '0;
        m_w2   = '0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] a, b, c);
        bit rdy, take, was_run;
        rdy     = !m_run || (m_cnt == FL - 1);
        take    = v && rdy;
        was_run = m_run;
`ifdef SNG_RESEED_EN
        if (take) m_lfsr = SEED;
        else if (was_run) m_lfsr = lfsr_next(m_lfsr);
`else
        if (was_run) m_lfsr = lfsr_next(m_lfsr);
`endif
        if (!m_run) begin
            if (take) begin
                m_run = 1'b1;
                m_cnt = 0;
            end
        end else if (m_cnt == FL - 1) begin
            m_cnt = 0;
            m_run = take;
        end else begin
            m_cnt++;
        end
        if (take) begin
            m_w1 = a;
            m_i1 = b;
            m_w2 = c;
        end
    endtask

    logic [21:0] sb_q[$];
    logic [21:0] sb_exp;
    logic [21:0] dut_obs;

    assign dut_obs = {in_ready, bs_valid, Nc, w1_bs, i1_bs, w2_bs, rand_word};

    // Expected values are pushed at the clock edge and compared at the next falling edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            sb_exp = sb_q.pop_front();
            checkOutput("cycle", 32'(dut_obs), 32'(sb_exp));
        end
    end

    int nc_seen;
    int nc_first;
    int bsv_low;
    int call_idx;

    task automatic applyStimulus(input bit v, input logic [15:0] a, b, c);
        in_valid = v;
        w1_val   = a;
        i1_val   = b;
        w2_val   = c;
        @(posedge clk);
        model_step(v, a, b, c);
        sb_q.push_back(model_outputs());
        #1;
        if (Nc) begin
            if (nc_seen == 0) nc_first = call_idx;
            nc_seen++;
        end
        if (!bs_valid) bsv_low++;
        call_idx++;
    endtask

    task automatic applyReset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_bs_valid", 32'(bs_valid), 32'd0);
        checkOutput("rst_nc", 32'(Nc), 32'd0);
        checkOutput("rst_rand", 32'(rand_word), 32'(SEED));
        checkOutput("rst_streams", 32'({w1_bs, i1_bs, w2_bs}), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_rand", 32'(rand_word), 32'(SEED));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic clearTally();
        nc_seen  = 0;
        nc_first = -1;
        bsv_low  = 0;
        call_idx = 0;
    endtask

    bit long_done = 1'b0;

    // Full-period run: every non-zero LFSR word appears exactly once in one frame.
    initial begin
        int w1_ones, i1_ones, w2_ones, nc_n, nc_at, valid_n;
        w1_ones = 0; i1_ones = 0; w2_ones = 0; nc_n = 0; nc_at = -1; valid_n = 0;
        rst_n_long    = 1'b0;
        in_valid_long = 1'b0;
        w1_val_long   = '0;
        i1_val_long   = '0;
        w2_val_long   = '0;
        repeat (2) @(negedge clk);
        rst_n_long = 1'b1;
        @(negedge clk);
        in_valid_long = 1'b1;
        w1_val_long   = 16'h8000;
        i1_val_long   = 16'h0000;
        w2_val_long   = 16'hFFFF;
        checkOutput("long_ready", 32'(in_ready_long), 32'd1);
        @(posedge clk);
        #1;
        in_valid_long = 1'b0;
        for (int k = 1; k <= FL_LONG; k++) begin
            if (bs_valid_long) begin
                valid_n++;
                if (w1_bs_long) w1_ones++;
                if (i1_bs_long) i1_ones++;
                if (w2_bs_long) w2_ones++;
            end
            if (Nc_long) begin
                nc_n++;
                nc_at = k;
            end
            if (k < FL_LONG) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("long_w1_ones", 32'(w1_ones), 32'd32767);
        checkOutput("long_i1_ones", 32'(i1_ones), 32'd0);
        checkOutput("long_w2_ones", 32'(w2_ones), 32'd65534);
        checkOutput("long_valid_cycles", 32'(valid_n), 32'(FL_LONG));
        checkOutput("long_nc_count", 32'(nc_n), 32'd1);
        checkOutput("long_nc_cycle", 32'(nc_at), 32'(FL_LONG));
        checkOutput("long_idle_after", 32'({bs_valid_long, in_ready_long}), 32'b01);
        long_done = 1'b1;
    end

    logic [15:0] set_w1[4] = '{16'h8000, 16'h1234, 16'hFFFF, 16'h0001};
    logic [15:0] set_i1[4] = '{16'h4000, 16'hFFFF, 16'h0000, 16'hA5A5};
    logic [15:0] set_w2[4] = '{16'hC000, 16'h0000, 16'h7FFF, 16'h5A5A};

    initial begin
        logic [FL-1:0] frame_a, frame_b;
        int            guard;
        bit            reseed;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        w1_val   = '0;
        i1_val   = '0;
        w2_val   = '0;
        clearTally();
        model_reset();

        applyReset();
        repeat (3) applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);

        // in_valid held high: new operands offered right after each acceptance.
        clearTally();
        for (int k = 0; k < 3 * FL; k++) begin
            int s;
            s = (k + FL - 1) / FL;
            applyStimulus(1'b1, set_w1[s], set_i1[s], set_w2[s]);
        end
        checkOutput("held_nc_count", 32'(nc_seen), 32'd3);
        checkOutput("held_nc_first", 32'(nc_first), 32'(FL - 1));
        checkOutput("held_bsv_drop", 32'(bsv_low), 32'd0);
        repeat (2) applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);

        // A mid-frame in_valid pulse must be ignored.
        clearTally();
        applyStimulus(1'b1, 16'h0F0F, 16'h7777, 16'h9999);
        for (int k = 1; k < FL; k++) begin
            if (k == 11) begin
                checkOutput("midframe_ready", 32'(in_ready), 32'd0);
                applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            end else begin
                applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);
            end
        end
        checkOutput("midframe_nc_count", 32'(nc_seen), 32'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);

        // Asynchronous reset at bit 100 aborts the frame, then a fresh full frame runs.
        clearTally();
        applyStimulus(1'b1, 16'h8000, 16'h8000, 16'h8000);
        for (int k = 1; k <= 100; k++) applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);
        applyReset();
        checkOutput("abort_nc_count", 32'(nc_seen), 32'd0);
        clearTally();
        applyStimulus(1'b1, 16'h3000, 16'hE000, 16'h0000);
        for (int k = 1; k < FL; k++) applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);
        checkOutput("after_abort_nc_count", 32'(nc_seen), 32'd1);
        checkOutput("after_abort_nc_pos", 32'(nc_first), 32'(FL - 1));
        checkOutput("after_abort_bsv_drop", 32'(bsv_low), 32'd0);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);

        // Two frames with equal operands: identical only when reseeding per transfer.
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < FL; k++) begin
                applyStimulus(k == 0, 16'h8000, 16'h8000, 16'h8000);
                if (f == 0) frame_a[k] = w1_bs;
                else frame_b[k] = w1_bs;
            end
            repeat (2) applyStimulus(1'b0, 16'h0, 16'h0, 16'h0);
        end
`ifdef SNG_RESEED_EN
        reseed = 1'b1;
`else
        reseed = 1'b0;
`endif
        checkOutput("frame_repeat", 32'(frame_a == frame_b), 32'(reseed));

        guard = 0;
        while (!long_done && guard < 70000) begin
            @(posedge clk);
            guard++;
        end
        checkOutput("long_done", 32'(long_done), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
